// File: rtl/i2s_rx_stereo_if.sv
// Codec-side serial inputs and stereo sample outputs of the I2S receiver.
// The master drives the serial lines; the receiver is the slave.
interface i2s_rx_stereo_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  enable;
    logic                  CLRCLK;
    logic                  in;
    logic [DATA_WIDTH-1:0] left_data;
    logic [DATA_WIDTH-1:0] right_data;
    logic                  ready;
    logic                  frame_err;

    modport master (
        output enable,
        output CLRCLK,
        output in,
        input  left_data,
        input  right_data,
        input  ready,
        input  frame_err
    );

    modport slave (
        input  enable,
        input  CLRCLK,
        input  in,
        output left_data,
        output right_data,
        output ready,
        output frame_err
    );
endinterface

// File: rtl/i2s_rx_stereo.sv
// Stereo I2S / left-justified receiver in the codec bit-clock domain.
// Emits a left/right pair with a one-cycle ready strobe per frame.
module i2s_rx_stereo #(
    parameter int DATA_WIDTH = 16,
    parameter bit LJ_MODE    = 1'b0
) (
    input logic           clock_i,
    input logic           reset_i,
    i2s_rx_stereo_if.slave bus
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        SYNC,
        SHIFT_L,
        WAIT_L,
        SHIFT_R,
        WAIT_R
    } state_e;

    state_e          state_q, state_d;
    logic            lr_q;
    logic [CW-1:0]   bitcnt_q, bitcnt_d;
    word_t           sreg_q, sreg_d;
    word_t           hold_q, hold_d;
    word_t           left_q, left_d;
    word_t           right_q, right_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;

    logic            edge_w;
    logic            fall_w;
    logic            rise_w;
    logic            last_w;
    logic            corner_w;
    logic            go_l;
    logic            go_r;
    word_t           shifted_w;
    word_t           start_sreg;
    logic [CW-1:0]   start_cnt;

    assign edge_w    = bus.CLRCLK ^ lr_q;
    assign fall_w    = edge_w & ~bus.CLRCLK;
    assign rise_w    = edge_w & bus.CLRCLK;
    assign last_w    = (bitcnt_q == LAST);
    assign shifted_w = {sreg_q[DATA_WIDTH-2:0], bus.in};

    // An I2S slot of exactly DATA_WIDTH bits puts its LSB on the next edge.
    assign corner_w  = last_w & ~LJ_MODE;

    // LJ takes the MSB on the edge cycle; I2S skips it.
    assign start_sreg = LJ_MODE ? {{(DATA_WIDTH-1){1'b0}}, bus.in} : '0;
    assign start_cnt  = LJ_MODE ? CW'(1) : '0;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sreg_d   = sreg_q;
        hold_d   = hold_q;
        left_d   = left_q;
        right_d  = right_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        go_l     = 1'b0;
        go_r     = 1'b0;

        if (!bus.enable) begin
            state_d  = SYNC;
            bitcnt_d = '0;
            sreg_d   = '0;
            hold_d   = '0;
        end else begin
            unique case (state_q)
                SYNC: begin
                    go_l = fall_w;
                end
                SHIFT_L, SHIFT_R: begin
                    if (edge_w && !corner_w) begin
                        err_d  = ~err_q;
                        hold_d = '0;
                        if (fall_w) begin
                            go_l = 1'b1;
                        end else begin
                            state_d  = SYNC;
                            bitcnt_d = '0;
                            sreg_d   = '0;
                        end
                    end else if (last_w) begin
                        if (state_q == SHIFT_L) begin
                            hold_d  = shifted_w;
                            state_d = WAIT_L;
                            go_r    = rise_w;
                        end else begin
                            right_d = shifted_w;
                            left_d  = hold_q;
                            ready_d = 1'b1;
                            state_d = WAIT_R;
                            go_l    = fall_w;
                        end
                    end else begin
                        sreg_d   = shifted_w;
                        bitcnt_d = bitcnt_q + CW'(1);
                    end
                end
                WAIT_L: begin
                    go_r = rise_w;
                end
                WAIT_R: begin
                    go_l = fall_w;
                end
                default: begin
                    state_d = SYNC;
                end
            endcase

            if (go_l) begin
                state_d  = SHIFT_L;
                sreg_d   = start_sreg;
                bitcnt_d = start_cnt;
            end
            if (go_r) begin
                state_d  = SHIFT_R;
                sreg_d   = start_sreg;
                bitcnt_d = start_cnt;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= SYNC;
            lr_q     <= bus.CLRCLK;
            bitcnt_q <= '0;
            sreg_q   <= '0;
            hold_q   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lr_q     <= bus.CLRCLK;
            bitcnt_q <= bitcnt_d;
            sreg_q   <= sreg_d;
            hold_q   <= hold_d;
            left_q   <= left_d;
            right_q  <= right_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign bus.left_data  = left_q;
    assign bus.right_data = right_q;
    assign bus.ready      = ready_q;
    assign bus.frame_err  = err_q;

endmodule
